// File: rtl/b_instr_encoder_if.sv
// Request/response bundle for b_instr_encoder.
// master: the requester (drives requests, consumes results).
// slave : the encoder (accepts requests, produces results).
interface b_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_pc;
    logic [63:0] in_target;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_err;

    modport master (
        output in_valid, in_op, in_pc, in_target, in_rt, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_op, in_pc, in_target, in_rt, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/b_instr_encoder.sv
// b_instr_encoder: builds A64 B/BL/CBZ/CBNZ/B.cond words from (kind, pc, target).
// Two-stage pipeline: S1 holds op/rt/byte offset, S2 holds the checked, packed word.
// Optional statistics counters are compiled in with `define B_ENC_STATS_EN.
module b_instr_encoder
`ifdef B_ENC_STATS_EN
#(
    parameter int CNT_WIDTH = 16
)
`endif
(
    input  logic             clk,
    input  logic             reset_n,
    b_instr_encoder_if.slave bus
`ifdef B_ENC_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] enc_count,
    output logic [CNT_WIDTH-1:0] err_count
`endif
);

    typedef enum logic [2:0] {
        OP_B     = 3'd0,
        OP_BL    = 3'd1,
        OP_CBZ   = 3'd2,
        OP_CBNZ  = 3'd3,
        OP_BCOND = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_OP    = 2'd3
    } err_e;

    // Stage 1 state
    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_op_q,    s1_op_d;
    logic [4:0]  s1_rt_q,    s1_rt_d;
    logic [63:0] s1_off_q,   s1_off_d;

    // Stage 2 state (drives the outputs directly)
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_instr_q, s2_instr_d;
    logic [1:0]  s2_err_q,   s2_err_d;

    logic        s1_adv;
    logic        in_fire;
    logic [31:0] enc_instr;
    err_e        enc_err;
    logic        fits_26;
    logic        fits_19;

    // S1 may move into S2 whenever S2 is empty or is being drained this cycle.
    assign s1_adv   = !s2_valid_q || bus.out_ready;
    assign in_fire  = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !s1_valid_q || s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_instr = s2_instr_q;
    assign bus.out_err   = s2_err_q;

    // The offset fits a signed field when every bit above the field's sign bit matches it.
    assign fits_26 = (&s1_off_q[63:27]) || !(|s1_off_q[63:27]);
    assign fits_19 = (&s1_off_q[63:20]) || !(|s1_off_q[63:20]);

    // Check (illegal op > misaligned > out of range) and pack the S1 contents.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        enc_err   = ERR_OK;
        enc_instr = '0;
        if (s1_op_q > OP_BCOND) begin
            enc_err = ERR_OP;
        end else if (s1_off_q[1:0] != 2'b00) begin
            enc_err = ERR_ALIGN;
        end else begin
            unique case (s1_op_q)
                OP_B: begin
                    if (fits_26) enc_instr = {6'b000101, s1_off_q[27:2]};
                    else         enc_err   = ERR_RANGE;
                end
                OP_BL: begin
                    if (fits_26) enc_instr = {6'b100101, s1_off_q[27:2]};
                    else         enc_err   = ERR_RANGE;
                end
                OP_CBZ: begin
                    if (fits_19) enc_instr = {8'b10110100, s1_off_q[20:2], s1_rt_q};
                    else         enc_err   = ERR_RANGE;
                end
                OP_CBNZ: begin
                    if (fits_19) enc_instr = {8'b10110101, s1_off_q[20:2], s1_rt_q};
                    else         enc_err   = ERR_RANGE;
                end
                default: begin
                    if (fits_19) enc_instr = {8'b01010100, s1_off_q[20:2], 1'b0, s1_rt_q[3:0]};
                    else         enc_err   = ERR_RANGE;
                end
            endcase
        end
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_rt_d    = s1_rt_q;
        s1_off_d   = s1_off_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;

        if (bus.in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_fire) begin
            s1_op_d  = bus.in_op;
            s1_rt_d  = bus.in_rt;
            s1_off_d = bus.in_target - bus.in_pc;
        end

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = enc_instr;
                s2_err_d   = enc_err;
            end
        end
    end

    // Pipeline registers; an async reset drops anything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_rt_q    <= '0;
            s1_off_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_rt_q    <= s1_rt_d;
            s1_off_q   <= s1_off_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
        end
    end

`ifdef B_ENC_STATS_EN
    logic                 out_fire;
    logic [CNT_WIDTH-1:0] enc_count_q, enc_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    assign out_fire  = s2_valid_q && bus.out_ready;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

    // Saturating counts of good and failed results as they leave the block.
    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (out_fire) begin
            if (s2_err_q == ERR_OK) begin
                if (enc_count_q != '1) enc_count_d = enc_count_q + 1'b1;
            end else begin
                if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_b_instr_encoder.sv
// Self-checking bench for b_instr_encoder: a scoreboard queue holds expected
// {err, instr} per accepted request; a monitor pops and compares on each output transfer.
module tb_b_instr_encoder;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    logic [33:0] exp_q[$];
    int          exp_ok_cnt;
    int          exp_err_cnt;

    b_instr_encoder_if bus ();

`ifdef B_ENC_STATS_EN
    logic [15:0] enc_count;
    logic [15:0] err_count;
`endif

    b_instr_encoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef B_ENC_STATS_EN
        ,
        .enc_count (enc_count),
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: signed-integer range checks, independent of bit-pattern tests.
    function automatic logic [33:0] model(input logic [2:0] op, input logic [63:0] pc,
                                          input logic [63:0] tgt, input logic [4:0] rt);
        logic [63:0] diff;
        longint      off;
        logic [63:0] imm;
        logic [1:0]  err;
        logic [31:0] w;
        diff = tgt - pc;
        off  = longint'(diff);
        imm  = 64'(off >>> 2);
        err  = 2'd0;
        w    = 32'd0;
        if (op > 3'd4) err = 2'd3;
        else if (diff[1:0] != 2'b00) err = 2'd1;
        else if (op <= 3'd1 && (off < -64'sd134217728 || off > 64'sd134217724)) err = 2'd2;
        else if (op >= 3'd2 && (off < -64'sd1048576 || off > 64'sd1048572)) err = 2'd2;
        else begin
            case (op)
                3'd0: w = {6'b000101, imm[25:0]};
                3'd1: w = {6'b100101, imm[25:0]};
                3'd2: w = {8'hB4, imm[18:0], rt};
                3'd3: w = {8'hB5, imm[18:0], rt};
                default: w = {8'h54, imm[18:0], 1'b0, rt[3:0]};
            endcase
        end
        return {err, w};
    endfunction

    // Scoreboard monitor: every output transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_output: got err=%0d instr=%h, required no output",
                         bus.out_err, bus.out_instr);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if (e[33:32] == 2'd0) exp_ok_cnt++; else exp_err_cnt++;
                if ({bus.out_err, bus.out_instr} !== e) begin
                    tests_failed++;
                    $display("FAIL result: got err=%0d instr=%h, required err=%0d instr=%h",
                             bus.out_err, bus.out_instr, e[33:32], e[31:0]);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [63:0] pc,
                         input logic [63:0] tgt, input logic [4:0] rt);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_pc     = pc;
        bus.in_target = tgt;
        bus.in_rt     = rt;
    endtask

    // Present one request (called at posedge+1), wait for acceptance, record expectation.
    task automatic send(input logic [2:0] op, input logic [63:0] pc, input logic [63:0] tgt,
                        input logic [4:0] rt, input logic [33:0] e);
        int n;
        n = 0;
        drive(op, pc, tgt, rt);
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 100) break;
            @(posedge clk); #1;
        end
        if (n > 100) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, required 1");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_instr !== 32'd0 || bus.out_err !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b vld=%b instr=%h err=%0d, required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_instr, bus.out_err);
        end
`ifdef B_ENC_STATS_EN
        tests_run++;
        if (enc_count !== 16'd0 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: got %0d/%0d, required 0/0", enc_count, err_count);
        end
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        send(3'd0, 64'h1000, 64'h1002, 5'd0, {2'd1, 32'd0});
        send(3'd5, 64'h1000, 64'h1001, 5'd0, {2'd3, 32'd0});
        send(3'd0, 64'h0,    64'h8000000, 5'd0, {2'd2, 32'd0});
        wait_drain();
`ifdef B_ENC_STATS_EN
        @(negedge clk);
        tests_run++;
        if (err_count !== 16'd3 || enc_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL err_count: got err=%0d enc=%0d, required err=3 enc=0",
                     err_count, enc_count);
        end
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_b_bl();
        send(3'd0, 64'h1000, 64'h1010, 5'd0, {2'd0, 32'h14000004});
        // accept was the previous cycle: result must appear one cycle later, not now
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early: got out_valid=%b one cycle after accept, required 0",
                     bus.out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency: got out_valid=%b two cycles after accept, required 1",
                     bus.out_valid);
        end
        @(posedge clk); #1;
        send(3'd1, 64'h2000, 64'h1FFC, 5'd0, {2'd0, 32'h97FFFFFF});
        send(3'd0, 64'h0, 64'h7FFFFFC, 5'd0, {2'd0, 32'h15FFFFFF});
        send(3'd0, 64'h0, 64'h8000000, 5'd0, {2'd2, 32'h0});
        send(3'd1, 64'h8000000, 64'h0, 5'd0, model(3'd1, 64'h8000000, 64'h0, 5'd0));
        send(3'd0, 64'h8000004, 64'h0, 5'd0, model(3'd0, 64'h8000004, 64'h0, 5'd0));
        send(3'd0, 64'h5000, 64'h5000, 5'd0, {2'd0, 32'h14000000});
        wait_drain();
    endtask

    task automatic test_cb_bcond();
        send(3'd2, 64'h100, 64'h120, 5'd3, {2'd0, 32'hB4000103});
        send(3'd4, 64'h0, 64'hFFFFC, 5'd1, {2'd0, 32'h547FFFE1});
        send(3'd4, 64'h0, 64'h100000, 5'd1, {2'd2, 32'h0});
        send(3'd3, 64'h200000, 64'h100000, 5'd31, model(3'd3, 64'h200000, 64'h100000, 5'd31));
        send(3'd3, 64'h200000, 64'h0FFFFC, 5'd7, model(3'd3, 64'h200000, 64'h0FFFFC, 5'd7));
        send(3'd4, 64'h40, 64'h0, 5'd30, model(3'd4, 64'h40, 64'h0, 5'd30));
        wait_drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  op;
            logic [63:0] pc;
            logic [63:0] off;
            logic [4:0]  rt;
            op = 3'($urandom_range(0, 7));
            pc = {$urandom, $urandom};
            rt = 5'($urandom);
            case ($urandom_range(0, 3))
                0: off = 64'(longint'($urandom_range(0, 4000)) * 4 - 8000);
                1: off = 64'(longint'($signed($urandom)));
                2: off = 64'(longint'($urandom_range(0, 1 << 20)) * 4 - (1 << 21));
                default: off = 64'(longint'($urandom_range(0, 5000)) * 4 + 2);
            endcase
            send(op, pc, pc + off, rt, model(op, pc, pc + off, rt));
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [4];
        logic [63:0] pcs [4];
        logic [63:0] tgs [4];
        logic [4:0]  rts [4];
        logic [33:0] held;
        logic        have;
        int          idx;
        int          n;
        ops = '{3'd0, 3'd2, 3'd4, 3'd1};
        pcs = '{64'h1000, 64'h300, 64'h0, 64'h4000};
        tgs = '{64'h1100, 64'h200, 64'h200002, 64'h4800};
        rts = '{5'd0, 5'd9, 5'd5, 5'd0};
        have = 1'b0;
        held = '0;
        idx  = 0;
        bus.out_ready = 1'b0;
        drive(ops[0], pcs[0], tgs[0], rts[0]);
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(ops[idx], pcs[idx], tgs[idx], rts[idx]));
                idx++;
            end
            if (bus.out_valid) begin
                if (!have) begin
                    held = {bus.out_err, bus.out_instr};
                    have = 1'b1;
                end else begin
                    tests_run++;
                    if ({bus.out_err, bus.out_instr} !== held) begin
                        tests_failed++;
                        $display("FAIL hold_stable: got %h, required %h",
                                 {bus.out_err, bus.out_instr}, held);
                    end
                end
            end
            @(posedge clk); #1;
            if (idx < 4) drive(ops[idx], pcs[idx], tgs[idx], rts[idx]);
            else bus.in_valid = 1'b0;
        end
        tests_run++;
        if (idx != 2 || bus.in_ready !== 1'b0 || !have) begin
            tests_failed++;
            $display("FAIL backpressure: got accepted=%0d in_ready=%b seen=%b, required 2 0 1",
                     idx, bus.in_ready, have);
        end
        bus.out_ready = 1'b1;
        n = 0;
        while (idx < 4 && n < 50) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(ops[idx], pcs[idx], tgs[idx], rts[idx]));
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) drive(ops[idx], pcs[idx], tgs[idx], rts[idx]);
            else bus.in_valid = 1'b0;
            n++;
        end
        bus.in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        send(3'd0, 64'h0, 64'h40, 5'd0, model(3'd0, 64'h0, 64'h40, 5'd0));
        send(3'd1, 64'h0, 64'h80, 5'd0, model(3'd1, 64'h0, 64'h80, 5'd0));
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ok_cnt  = 0;
        exp_err_cnt = 0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_instr !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got vld=%b rdy=%b instr=%h, required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.out_instr);
        end
`ifdef B_ENC_STATS_EN
        tests_run++;
        if (enc_count !== 16'd0 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_counters_mid: got %0d/%0d, required 0/0", enc_count, err_count);
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stale_result: got out_valid=%b after reset, required 0",
                         bus.out_valid);
            end
        end
        @(posedge clk); #1;
        send(3'd2, 64'h100, 64'h120, 5'd3, {2'd0, 32'hB4000103});
        wait_drain();
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        exp_ok_cnt    = 0;
        exp_err_cnt   = 0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_pc     = '0;
        bus.in_target = '0;
        bus.in_rt     = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_errors();
        test_b_bl();
        test_cb_bcond();
        test_random();
        test_back_to_back();
`ifdef B_ENC_STATS_EN
        @(negedge clk);
        tests_run++;
        if (enc_count !== 16'(exp_ok_cnt) || err_count !== 16'(exp_err_cnt)) begin
            tests_failed++;
            $display("FAIL stats_totals: got enc=%0d err=%0d, required enc=%0d err=%0d",
                     enc_count, err_count, exp_ok_cnt, exp_err_cnt);
        end
        @(posedge clk); #1;
`endif
        test_reset_midstream();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
